// File: rtl/dsp_post_adder_acc.sv
// DSP48A1-style post-adder / accumulator with P, PCOUT and CARRYOUT.
// Optional pattern detector enabled by defining PATTERN_DETECT_EN.
module dsp_post_adder_acc #(
    parameter int PREG       = 1,
    parameter int OPMODEREG  = 1,
    parameter int CARRYINREG = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_p,
    input  logic        ce_opmode,
    input  logic        ce_carryin,
    input  logic        clr_p,
    input  logic [7:0]  opmode,
    input  logic [35:0] m,
    input  logic [47:0] c,
    input  logic [47:0] pcin,
    input  logic [17:0] d,
    input  logic [17:0] a,
    input  logic [17:0] b,
`ifdef PATTERN_DETECT_EN
    input  logic [47:0] pattern,
    input  logic [47:0] mask,
    output logic        pattern_det,
`endif
    output logic [47:0] p,
    output logic [47:0] pcout,
    output logic        carryout
);

    // {subtract, zsel[1:0], xsel[1:0]}
    logic [4:0]  opm;
    logic        cin;
    logic [47:0] x_op;
    logic [47:0] z_op;
    logic [48:0] sum_d;
    logic [47:0] p_int;
    logic        co_int;
    logic        unused_bits;

    assign unused_bits = ^{opmode[6], opmode[4], d[17:12], ce_p, clr_p};

    generate
        if (OPMODEREG != 0) begin : g_opreg
            logic [4:0] opm_q;
            // Capture the used OPMODE bits ahead of the adder
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    opm_q <= '0;
                else if (ce_opmode)
                    opm_q <= {opmode[7], opmode[3:0]};
            end
            assign opm = opm_q;
        end else begin : g_opdir
            assign opm = {opmode[7], opmode[3:0]};
        end

        if (CARRYINREG != 0) begin : g_cireg
            logic cin_q;
            // Capture carry-in alongside OPMODE
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    cin_q <= 1'b0;
                else if (ce_carryin)
                    cin_q <= opmode[5];
            end
            assign cin = cin_q;
        end else begin : g_cidir
            assign cin = opmode[5];
        end
    endgenerate

    // Operand muxes and 49-bit add/subtract
    always_comb begin
        x_op = '0;
        z_op = '0;
        case (opm[1:0])
            2'd0:    x_op = '0;
            2'd1:    x_op = {{12{m[35]}}, m};
            2'd2:    x_op = p_int;
            default: x_op = {d[11:0], a, b};
        endcase
        case (opm[3:2])
            2'd0:    z_op = '0;
            2'd1:    z_op = pcin;
            2'd2:    z_op = p_int;
            default: z_op = c;
        endcase
        if (opm[4])
            sum_d = {1'b0, z_op} - ({1'b0, x_op} + {48'd0, cin});
        else
            sum_d = {1'b0, z_op} + {1'b0, x_op} + {48'd0, cin};
    end

`ifdef PATTERN_DETECT_EN
    logic pd_d;
    logic pd_int;
    assign pd_d = ~|((sum_d[47:0] ^ pattern) & ~mask);
`endif

    generate
        if (PREG != 0) begin : g_preg
            logic [47:0] p_q;
            logic        co_q;
            // Result register; clear wins over enable
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    p_q  <= '0;
                    co_q <= 1'b0;
                end else if (clr_p) begin
                    p_q  <= '0;
                    co_q <= 1'b0;
                end else if (ce_p) begin
                    p_q  <= sum_d[47:0];
                    co_q <= sum_d[48];
                end
            end
            assign p_int  = p_q;
            assign co_int = co_q;
`ifdef PATTERN_DETECT_EN
            logic pd_q;
            // Pattern flag aligned with the P register
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    pd_q <= 1'b0;
                else if (clr_p)
                    pd_q <= 1'b0;
                else if (ce_p)
                    pd_q <= pd_d;
            end
            assign pd_int = pd_q;
`endif
        end else begin : g_pcomb
            assign p_int  = sum_d[47:0];
            assign co_int = sum_d[48];
`ifdef PATTERN_DETECT_EN
            assign pd_int = pd_d;
`endif
        end
    endgenerate

    assign p        = p_int;
    assign pcout    = p_int;
    assign carryout = co_int;
`ifdef PATTERN_DETECT_EN
    assign pattern_det = pd_int;
`endif

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Directed bench for dsp_post_adder_acc (default parameters).
module tb_dsp_post_adder_acc;

    localparam int PREG_TB = 1;

    logic        clk;
    logic        rst;
    logic        ce_p;
    logic        ce_opmode;
    logic        ce_carryin;
    logic        clr_p;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [47:0] c;
    logic [47:0] pcin;
    logic [17:0] d;
    logic [17:0] a;
    logic [17:0] b;
    logic [47:0] p;
    logic [47:0] pcout;
    logic        carryout;
`ifdef PATTERN_DETECT_EN
    logic [47:0] pattern;
    logic [47:0] mask;
    logic        pattern_det;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [47:0] exp_cat;

    dsp_post_adder_acc #(
        .PREG(PREG_TB),
        .OPMODEREG(1),
        .CARRYINREG(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce_p(ce_p),
        .ce_opmode(ce_opmode),
        .ce_carryin(ce_carryin),
        .clr_p(clr_p),
        .opmode(opmode),
        .m(m),
        .c(c),
        .pcin(pcin),
        .d(d),
        .a(a),
        .b(b),
`ifdef PATTERN_DETECT_EN
        .pattern(pattern),
        .mask(mask),
        .pattern_det(pattern_det),
`endif
        .p(p),
        .pcout(pcout),
        .carryout(carryout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [48:0] obs,
                       input logic [48:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    task automatic set_op(input logic [7:0] op);
        if (PREG_TB == 0 && (op[1:0] == 2'd2 || op[3:2] == 2'd2)) begin
            $display("FAIL feedback_preg0: opmode %h loops with PREG=0", op);
            $fatal(1);
        end
        opmode = op;
    endtask

    initial begin
        rst = 1'b0;
        ce_p = 1'b1;
        ce_opmode = 1'b1;
        ce_carryin = 1'b1;
        clr_p = 1'b0;
        set_op(8'h0D);
        m = 36'd5;
        c = 48'd100;
        pcin = 48'h123;
        d = 18'h3FF;
        a = 18'h155;
        b = 18'h2AA;
`ifdef PATTERN_DETECT_EN
        pattern = '0;
        mask = '1;
`endif

        // reset held with enables and operands active
        step(3);
        chk("rst_p", {1'b0, p}, 49'd0);
        chk("rst_pcout", {1'b0, pcout}, 49'd0);
        chk("rst_co", {48'd0, carryout}, 49'd0);

        // release: opmode register adds one edge
        rst = 1'b1;
        step(1);
        chk("first_edge", {1'b0, p}, 49'd0);
        step(1);
        chk("m_plus_c", {1'b0, p}, 49'd105);
        chk("m_plus_c_co", {48'd0, carryout}, 49'd0);

        // accumulate m=3 onto p
        set_op(8'h09);
        m = 36'd3;
        clr_p = 1'b1;
        step(1);
        chk("clr", {1'b0, p}, 49'd0);
        clr_p = 1'b0;
        step(10);
        chk("acc10", {1'b0, p}, 49'd30);
        ce_p = 1'b0;
        step(3);
        chk("hold", {1'b0, p}, 49'd30);

        // clear overrides enable
        clr_p = 1'b1;
        ce_p = 1'b1;
        step(1);
        chk("clr_over_ce", {1'b0, p}, 49'd0);
        clr_p = 1'b0;
        step(4);
        chk("acc4", {1'b0, p}, 49'd12);

        // asynchronous reset between edges
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_p", {1'b0, p}, 49'd0);
        chk("async_rst_pcout", {1'b0, pcout}, 49'd0);
        #1;
        rst = 1'b1;
        step(1);
        chk("restart0", {1'b0, p}, 49'd0);
        step(2);
        chk("restart6", {1'b0, p}, 49'd6);

        // subtract: c - m = 10 - 25
        set_op(8'h8D);
        c = 48'd10;
        m = 36'd25;
        step(2);
        chk("sub_p", {1'b0, p}, {1'b0, 48'hFFFF_FFFF_FFF1});
        chk("sub_co", {48'd0, carryout}, 49'd1);

        // negative m sign-extended: c + (-2)
        set_op(8'h0D);
        m = 36'hF_FFFF_FFFE;
        c = 48'd7;
        step(2);
        chk("neg_m", {1'b0, p}, 49'd5);

        // wrap: all-ones + carry-in
        set_op(8'h2C);
        c = 48'hFFFF_FFFF_FFFF;
        step(2);
        chk("wrap_p", {1'b0, p}, 49'd0);
        chk("wrap_co", {48'd0, carryout}, 49'd1);

        // concat X with pcin cascade
        set_op(8'h07);
        pcin = 48'd1;
        d = 18'h0AB;
        a = 18'h00001;
        b = 18'h00002;
        exp_cat = 48'h0AB0_0004_0003;
        step(2);
        chk("cat_p", {1'b0, p}, {1'b0, exp_cat});
        chk("cat_pcout", {1'b0, pcout}, {1'b0, exp_cat});
        chk("cat_co", {48'd0, carryout}, 49'd0);

        // both operands from p: 2p
        set_op(8'h0A);
        step(1);
        chk("op_lag", {1'b0, p}, {1'b0, exp_cat});
        step(1);
        chk("dbl_p", {1'b0, p}, {1'b0, exp_cat + exp_cat});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
